// File: rtl/alu_op_sequencer_if.sv
// Program-memory and ALU-core bus between alu_op_sequencer (master) and the
// memory/core pair (slave).
interface alu_op_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] pm_addr;
    logic [15:0]       pm_data;
    logic [7:0]        data_in;
    logic [6:0]        opcode;
    logic              cin;
    logic              load;
    logic              ce;
    logic              cout;
    logic [7:0]        data_out;

    modport master (
        output pm_addr, data_in, opcode, cin, load, ce,
        input  pm_data, cout, data_out
    );

    modport slave (
        input  pm_addr, data_in, opcode, cin, load, ce,
        output pm_data, cout, data_out
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit ALU core: one load or ce pulse per
// instruction, result and carry captured after the core latency, stops on HALT or illegal op.
module alu_op_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int EXEC_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    alu_op_sequencer_if.master bus,
    output logic [7:0]         result,
    output logic               carry,
    output logic               busy,
    output logic               done,
    output logic               error
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDI    = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam logic [2:0] WAIT_LAST = 3'(EXEC_LAT - 1);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pm_addr_r, pm_addr_s;
    logic [7:0]        data_in_r, data_in_s;
    logic [3:0]        opcode_r, opcode_s;
    logic              cin_r, cin_s;
    logic              load_r, load_s;
    logic              ce_r, ce_s;
    logic [2:0]        wait_cnt_r, wait_cnt_s;
    logic [7:0]        result_r, result_s;
    logic              carry_r, carry_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              error_r, error_s;
    logic [3:0]        dec_op_s;
    logic              unused_rsvd_s;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hD);
    endfunction

    assign dec_op_s      = bus.pm_data[15:12];
    // Reserved instruction bits [10:8] carry no meaning and are dropped here.
    assign unused_rsvd_s = ^bus.pm_data[10:8];

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_s    = state_r;
        pm_addr_s  = pm_addr_r;
        data_in_s  = data_in_r;
        opcode_s   = opcode_r;
        cin_s      = cin_r;
        wait_cnt_s = wait_cnt_r;
        result_s   = result_r;
        carry_s    = carry_r;
        busy_s     = busy_r;
        error_s    = error_r;
        load_s     = 1'b0;
        ce_s       = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    pm_addr_s = {ADDR_W{1'b0}};
                    busy_s    = 1'b1;
                    error_s   = 1'b0;
                    state_s   = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                state_s = S_DECODE;
            end
            S_DECODE: begin
                if (dec_op_s == OP_HALT) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end else if (is_illegal(dec_op_s)) begin
                    error_s = 1'b1;
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end else begin
                    data_in_s = bus.pm_data[7:0];
                    opcode_s  = dec_op_s;
                    cin_s     = bus.pm_data[11] & carry_r;
                    state_s   = S_EXEC;
                end
            end
            S_EXEC: begin
                // Pulse is registered on EXEC exit, so operands lead it by a full cycle.
                if (opcode_r == OP_LDI) begin
                    load_s = 1'b1;
                end else begin
                    ce_s = 1'b1;
                end
                wait_cnt_s = 3'd0;
                state_s    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s = S_WB;
                end else begin
                    wait_cnt_s = wait_cnt_r + 3'd1;
                end
            end
            S_WB: begin
                if (opcode_r == OP_LDI) begin
                    result_s = data_in_r;
                end else begin
                    result_s = bus.data_out;
                    carry_s  = bus.cout;
                end
                pm_addr_s = pm_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                state_s   = S_FETCH;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            pm_addr_r  <= {ADDR_W{1'b0}};
            data_in_r  <= 8'h00;
            opcode_r   <= 4'h0;
            cin_r      <= 1'b0;
            load_r     <= 1'b0;
            ce_r       <= 1'b0;
            wait_cnt_r <= 3'd0;
            result_r   <= 8'h00;
            carry_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            pm_addr_r  <= pm_addr_s;
            data_in_r  <= data_in_s;
            opcode_r   <= opcode_s;
            cin_r      <= cin_s;
            load_r     <= load_s;
            ce_r       <= ce_s;
            wait_cnt_r <= wait_cnt_s;
            result_r   <= result_s;
            carry_r    <= carry_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
        end
    end

    assign bus.pm_addr = pm_addr_r;
    assign bus.data_in = data_in_r;
    assign bus.opcode  = {3'b000, opcode_r};
    assign bus.cin     = cin_r;
    assign bus.load    = load_r;
    assign bus.ce      = ce_r;
    assign result      = result_r;
    assign carry       = carry_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: two sequencers (ADDR_W=6/EXEC_LAT=1 and ADDR_W=2/EXEC_LAT=3) share one
// program memory image and start/rst, each driving its own add-only core model.
module tb_alu_op_sequencer;
    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b1;
    logic       clr   = 1'b0;
    logic [7:0] result_a, result_b;
    logic       carry_a, carry_b, busy_a, busy_b, done_a, done_b, error_a, error_b;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 1;
    logic [15:0] prog [64];
    logic [7:0] acc_a, acc_b;
    logic       cy_a, cy_b;
    logic [8:0] pipe1_b, pipe2_b;

    alu_op_sequencer_if #(.ADDR_W(6)) bus_a ();
    alu_op_sequencer_if #(.ADDR_W(2)) bus_b ();

    alu_op_sequencer #(.ADDR_W(6), .EXEC_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .bus(bus_a),
        .result(result_a), .carry(carry_a), .busy(busy_a), .done(done_a), .error(error_a)
    );
    alu_op_sequencer #(.ADDR_W(2), .EXEC_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .bus(bus_b),
        .result(result_b), .carry(carry_b), .busy(busy_b), .done(done_b), .error(error_b)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] core_alu(input logic [6:0] opc, input logic [7:0] acc,
                                            input logic [7:0] din, input logic ci);
        if (opc == 7'd0) return {1'b0, acc} + {1'b0, din} + {8'd0, ci};
        else return {1'b0, acc};
    endfunction

    // Synchronous program memory and the two core models (B adds two extra output stages).
    always @(posedge clk) begin
        bus_a.pm_data <= prog[bus_a.pm_addr];
        bus_b.pm_data <= prog[{4'b0000, bus_b.pm_addr}];
        if (rst) begin
            acc_a <= 8'h00; cy_a <= 1'b0; acc_b <= 8'h00; cy_b <= 1'b0;
            pipe1_b <= 9'h000; pipe2_b <= 9'h000;
        end else begin
            if (bus_a.load) acc_a <= bus_a.data_in;
            else if (bus_a.ce) {cy_a, acc_a} <= core_alu(bus_a.opcode, acc_a, bus_a.data_in, bus_a.cin);
            if (bus_b.load) acc_b <= bus_b.data_in;
            else if (bus_b.ce) {cy_b, acc_b} <= core_alu(bus_b.opcode, acc_b, bus_b.data_in, bus_b.cin);
            pipe1_b <= {cy_b, acc_b};
            pipe2_b <= pipe1_b;
        end
    end
    assign bus_a.data_out = acc_a;
    assign bus_a.cout     = cy_a;
    assign bus_b.data_out = pipe2_b[7:0];
    assign bus_b.cout     = pipe2_b[8];

    logic [1:0] ce_v, load_v, done_v, err_v, busy_v, cin_v;
    logic [7:0] din_v [2];
    logic [5:0] addr_v [2];
    logic [6:0] op_v [2];
    logic [7:0] res_v [2];
    logic       carry_v [2];
    assign ce_v   = {bus_b.ce, bus_a.ce};
    assign load_v = {bus_b.load, bus_a.load};
    assign done_v = {done_b, done_a};
    assign err_v  = {error_b, error_a};
    assign busy_v = {busy_b, busy_a};
    assign cin_v  = {bus_b.cin, bus_a.cin};
    assign din_v[0]   = bus_a.data_in;
    assign din_v[1]   = bus_b.data_in;
    assign addr_v[0]  = bus_a.pm_addr;
    assign addr_v[1]  = {4'b0000, bus_b.pm_addr};
    assign op_v[0]    = bus_a.opcode;
    assign op_v[1]    = bus_b.opcode;
    assign res_v[0]   = result_a;
    assign res_v[1]   = result_b;
    assign carry_v[0] = carry_a;
    assign carry_v[1] = carry_b;

    int         ce_cnt [2], load_cnt [2], done_cnt [2], done_busy [2], gap [2], last_ce [2];
    logic [7:0] ce_din [2];
    logic [6:0] ce_op [2];
    logic       ce_cin [2];
    logic [5:0] ce_addr [2], ld_addr [2];
    int         overlap_cnt = 0;

    // Pulse monitor: counts and records what each sequencer shows at every clock edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if ((load_v[k] && ce_v[k]) || (done_v[k] && err_v[k])) overlap_cnt <= overlap_cnt + 1;
            if (clr) begin
                ce_cnt[k] <= 0; load_cnt[k] <= 0; done_cnt[k] <= 0; done_busy[k] <= 0;
                gap[k] <= 0; last_ce[k] <= 0;
            end else begin
                if (ce_v[k]) begin
                    ce_cnt[k]  <= ce_cnt[k] + 1;
                    ce_din[k]  <= din_v[k];
                    ce_op[k]   <= op_v[k];
                    ce_cin[k]  <= cin_v[k];
                    ce_addr[k] <= addr_v[k];
                    if (last_ce[k] != 0) gap[k] <= cyc - last_ce[k];
                    last_ce[k] <= cyc;
                end
                if (load_v[k]) begin
                    load_cnt[k] <= load_cnt[k] + 1;
                    ld_addr[k]  <= addr_v[k];
                end
                if (done_v[k]) begin
                    done_cnt[k] <= done_cnt[k] + 1;
                    if (busy_v[k]) done_busy[k] <= done_busy[k] + 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < 64; i++) prog[i] = 16'hF000;
        prog[0] = w0; prog[1] = w1; prog[2] = w2; prog[3] = w3;
    endtask

    task automatic start_run();
        clr = 1'b1; tick(); clr = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!busy_a && !busy_b) break;
            tick();
        end
        check_eq(tag, {busy_b, busy_a}, 2'b00);
        tick();
    endtask

    int nld;

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = 16'hF000;
        // Reset held three cycles with start asserted throughout.
        repeat (3) tick();
        check_eq("rst_outs_a", {bus_a.pm_addr, bus_a.data_in, bus_a.opcode, bus_a.cin, bus_a.load,
                 bus_a.ce, result_a, carry_a, busy_a, done_a, error_a}, 64'd0);
        check_eq("rst_outs_b", {bus_b.pm_addr, bus_b.data_in, bus_b.opcode, bus_b.cin, bus_b.load,
                 bus_b.ce, result_b, carry_b, busy_b, done_b, error_b}, 64'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check_eq("rst_start_ignored", {busy_b, busy_a}, 2'b00);

        // LDI 05 then ADD 03: 05+03 = 08, no carry.
        load_prog(16'hE005, 16'h0003, 16'hF000, 16'hF000);
        start_run();
        wait_idle("t2_timeout");
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("t2_load_cnt%0d", k), load_cnt[k], 1);
            check_eq($sformatf("t2_load_addr%0d", k), ld_addr[k], 0);
            check_eq($sformatf("t2_ce_cnt%0d", k), ce_cnt[k], 1);
            check_eq($sformatf("t2_ce_addr%0d", k), ce_addr[k], 1);
            check_eq($sformatf("t2_ce_op_din_cin%0d", k), {ce_op[k], ce_din[k], ce_cin[k]}, {7'd0, 8'h03, 1'b0});
            check_eq($sformatf("t2_result%0d", k), {res_v[k], carry_v[k]}, {8'h08, 1'b0});
            check_eq($sformatf("t2_done%0d", k), done_cnt[k], 1);
            check_eq($sformatf("t2_done_busy%0d", k), done_busy[k], 0);
        end

        // LDI FF, ADD 01 -> 00 carry 1, ADD 01 with use_c -> 00+01+1 = 02 carry 0.
        load_prog(16'hE0FF, 16'h0001, 16'h0801, 16'hF000);
        start_run();
        wait_idle("t3_timeout");
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("t3_ce_cnt%0d", k), ce_cnt[k], 2);
            check_eq($sformatf("t3_last_cin%0d", k), ce_cin[k], 1'b1);
            check_eq($sformatf("t3_result%0d", k), {res_v[k], carry_v[k]}, {8'h02, 1'b0});
        end

        // LDI 11 then illegal op B: error sticks, no ce, no done.
        load_prog(16'hE011, 16'hB000, 16'hF000, 16'hF000);
        start_run();
        wait_idle("t4_timeout");
        repeat (5) tick();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("t4_err_busy%0d", k), {err_v[k], busy_v[k]}, 2'b10);
            check_eq($sformatf("t4_ce_done%0d", k), {ce_cnt[k], done_cnt[k]}, 64'd0);
            check_eq($sformatf("t4_result%0d", k), res_v[k], 8'h11);
        end

        // Latency and spacing: LDI 01, ADD 01, ADD 02, with a start pulse mid-program.
        load_prog(16'hE001, 16'h0001, 16'h0002, 16'hF000);
        start_run();
        check_eq("t5_err_cleared", {error_b, error_a}, 2'b00);
        repeat (4) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_idle("t5_timeout");
        check_eq("t5_gap_a", gap[0], 5);
        check_eq("t5_gap_b", gap[1], 7);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("t5_ce_cnt%0d", k), ce_cnt[k], 2);
            check_eq($sformatf("t5_done%0d", k), done_cnt[k], 1);
            check_eq($sformatf("t5_result%0d", k), {res_v[k], carry_v[k]}, {8'h04, 1'b0});
        end

        // Four LDI words, no HALT: B wraps 3 -> 0, then rst lands in its EXEC cycle.
        load_prog(16'hE001, 16'hE002, 16'hE003, 16'hE004);
        start_run();
        nld = 0;
        for (int i = 0; i < 120; i++) begin
            if (bus_b.load) begin
                nld++;
                if (nld == 4) check_eq("t6_word3", {bus_b.pm_addr, bus_b.data_in}, {2'd3, 8'h04});
                if (nld == 5) break;
            end
            tick();
        end
        check_eq("t6_loads", nld, 5);
        check_eq("t6_wrap_word0", {bus_b.pm_addr, bus_b.data_in}, {2'd0, 8'h01});
        check_eq("t6_a_halted", {done_cnt[0], 24'd0, res_v[0]}, {32'd1, 24'd0, 8'h04});
        repeat (6) tick();
        rst = 1'b1; clr = 1'b1;
        tick();
        rst = 1'b0; clr = 1'b0;
        repeat (20) tick();
        check_eq("t6_no_pulse_after_rst", {load_cnt[1], ce_cnt[1]}, 64'd0);
        check_eq("t6_idle_after_rst", {busy_b, bus_b.pm_addr, bus_b.data_in, result_b}, 64'd0);

        check_eq("never_overlap", overlap_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
